// File: rtl/mc8123_pkg.sv
// Shared definitions for the MC8123 key path.
// The key address width is shared with the Z80 opcode/data decryptor, which
// indexes the key RAM with the same 13-bit address.
package mc8123_pkg;

  localparam int MC8123_KEY_AW   = 13;
  localparam int MC8123_KEY_SIZE = 1 << MC8123_KEY_AW;

  // Loader state, also exported on a debug port for checkers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } key_fsm_t;

endpackage

// File: rtl/mc8123_key_ram.sv
// Simple dual-port key RAM (2**AW x DW) on a single clock.
// One write port and one registered read port. The read is read-before-write:
// a same-address read and write in one cycle returns the old contents.
// No reset, so it maps onto block RAM.
// Ports:
//   clk    in   1   clock
//   we     in   1   write enable
//   waddr  in   AW  write address
//   wdata  in   DW  write data
//   raddr  in   AW  read address
//   rdata  out  DW  read data, one clock after raddr
module mc8123_key_ram
  import mc8123_pkg::*;
#(
  parameter int AW = MC8123_KEY_AW,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mc8123_key_loader.sv
// Writer side of the MC8123 decryption-key interface.
// Captures the 8 KB key from the ioctl download stream into a dual-port key
// RAM, serves the decryptor's key lookups, and reports whether a complete
// key is present.
//
// Handshake: ioctl_wr is a level strobe. Each rising edge of the registered
// strobe is one byte, however long the strobe stays high. There is no
// backpressure. key_a is accepted every cycle and key_d follows one clock later.
//
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   ioctl_downl  in   1   download active
//   ioctl_index  in   8   download stream index
//   ioctl_addr   in   25  byte address within stream
//   ioctl_dout   in   8   download data byte
//   ioctl_wr     in   1   write strobe
//   key_a        in   13  key lookup address
//   key_d        out  8   key byte (8'hFF while no valid key)
//   key_valid    out  1   complete key loaded since last download start
//   load_err     out  1   last key download ended with wrong byte count
//   key_count    out  14  key bytes accepted in current/last load
//   key_state    out  2   loader FSM state (debug)
module mc8123_key_loader
  import mc8123_pkg::*;
#(
  parameter logic [7:0]  KEY_INDEX = 8'h00,
  parameter logic [24:0] KEY_BASE  = 25'h030000,
  parameter int          KEY_AW    = MC8123_KEY_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  input  logic [KEY_AW-1:0] key_a,
  output logic [7:0]        key_d,
  output logic              key_valid,
  output logic              load_err,
  output logic [KEY_AW:0]   key_count,
  output key_fsm_t          key_state
);

  localparam logic [24:0]   KEY_SPAN   = 25'd1 << KEY_AW;
  localparam logic [KEY_AW:0] COUNT_FULL = {1'b1, {KEY_AW{1'b0}}};

  // Input stage: one register on every ioctl signal.
  logic        downl_r, downl_prev;
  logic        wr_r, wr_prev;
  logic [7:0]  index_r;
  logic [7:0]  dout_r;
  logic [24:0] addr_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      downl_r    <= 1'b0;
      downl_prev <= 1'b0;
      wr_r       <= 1'b0;
      wr_prev    <= 1'b0;
      index_r    <= 8'h00;
      dout_r     <= 8'h00;
      addr_r     <= 25'h0;
    end else begin
      downl_r    <= ioctl_downl;
      downl_prev <= downl_r;
      wr_r       <= ioctl_wr;
      wr_prev    <= wr_r;
      index_r    <= ioctl_index;
      dout_r     <= ioctl_dout;
      addr_r     <= ioctl_addr;
    end
  end

  logic        wr_pulse;
  logic        downl_rise;
  logic        downl_fall;
  logic        index_match;
  logic [24:0] offset;
  logic        in_range;
  logic        accept;
  key_fsm_t    state;

  assign wr_pulse    = wr_r & ~wr_prev;
  assign downl_rise  = downl_r & ~downl_prev;
  assign downl_fall  = ~downl_r & downl_prev;
  assign index_match = (index_r == KEY_INDEX);
  // Subtracting first keeps the upper bound free of overflow near the top of
  // the 25-bit address space. The lower bound catches the wrap below KEY_BASE.
  assign offset      = addr_r - KEY_BASE;
  assign in_range    = (addr_r >= KEY_BASE) && (offset < KEY_SPAN);
  assign accept      = (state == LOAD) && wr_pulse && index_match && in_range;

  // Loader FSM with the status outputs held in the same block. A final write
  // that coincides with the falling edge of downl is counted on the edge that
  // enters CHECK, so CHECK always sees the complete count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
      key_count <= '0;
    end else begin
      if (accept && (key_count != COUNT_FULL)) begin
        key_count <= key_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (downl_rise && index_match) begin
            state     <= LOAD;
            key_count <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        LOAD: begin
          if (downl_fall) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (key_count == COUNT_FULL) begin
            key_valid <= 1'b1;
          end else begin
            load_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_state = state;

  logic [7:0] ram_q;

  mc8123_key_ram #(
    .AW(KEY_AW),
    .DW(8)
  ) u_key_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (offset[KEY_AW-1:0]),
    .wdata (dout_r),
    .raddr (key_a),
    .rdata (ram_q)
  );

  // key_valid is registered alongside the RAM read, so the mux select lines up
  // with the data. It is reset, which forces key_d to 8'hFF at once on reset
  // even though the RAM output register has no reset.
  logic rd_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= key_valid;
    end
  end

  assign key_d = rd_valid_q ? ram_q : 8'hFF;

endmodule

// File: tb/tb_mc8123_key_loader.sv
`timescale 1ns/1ps
module tb_mc8123_key_loader;
  import mc8123_pkg::*;

  localparam logic [7:0]  KEY_INDEX = 8'h00;
  localparam logic [24:0] KEY_BASE  = 25'h030000;

  localparam int K_KEY_D  = 0;
  localparam int K_VALID  = 1;
  localparam int K_ERR    = 2;
  localparam int K_COUNT  = 3;
  localparam int K_STATE  = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_downl;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [12:0] key_a;
  logic [7:0]  key_d;
  logic        key_valid;
  logic        load_err;
  logic [13:0] key_count;
  key_fsm_t    key_state;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  mc8123_key_loader #(
    .KEY_INDEX (KEY_INDEX),
    .KEY_BASE  (KEY_BASE),
    .KEY_AW    (13)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .key_a       (key_a),
    .key_d       (key_d),
    .key_valid   (key_valid),
    .load_err    (load_err),
    .key_count   (key_count),
    .key_state   (key_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          kind_q[$];
  int          due_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        finished = 1'b0;

  function automatic string kind_name(input int k);
    case (k)
      K_KEY_D: return "key_d";
      K_VALID: return "key_valid";
      K_ERR:   return "load_err";
      K_COUNT: return "key_count";
      default: return "key_state";
    endcase
  endfunction

  // Entries carry the cycle on which they are due; they are compared on the
  // negedge of that cycle, away from the active edge.
  always @(negedge clk) begin
    int i;
    logic [15:0] act;
    i = 0;
    while (i < exp_q.size()) begin
      if (due_q[i] <= cycle) begin
        case (kind_q[i])
          K_KEY_D: act = {8'h00, key_d};
          K_VALID: act = {15'h0, key_valid};
          K_ERR:   act = {15'h0, load_err};
          K_COUNT: act = {2'b00, key_count};
          default: act = 16'(key_state);
        endcase
        n_checks++;
        if (act !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %h expected %h",
                   kind_name(kind_q[i]), cycle, act, exp_q[i]);
        end
        exp_q.delete(i);
        kind_q.delete(i);
        due_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int kind, input logic [15:0] val, input int due);
    exp_q.push_back(val);
    kind_q.push_back(kind);
    due_q.push_back(due);
  endtask

  task automatic expect_status(input logic v, input logic e, input int cnt,
                               input key_fsm_t st);
    expect_at(K_VALID, {15'h0, v}, cycle);
    expect_at(K_ERR,   {15'h0, e}, cycle);
    expect_at(K_COUNT, 16'(cnt),   cycle);
    expect_at(K_STATE, 16'(st),    cycle);
  endtask

  task automatic check_key(input logic [12:0] a, input logic [7:0] exp);
    key_a = a;
    expect_at(K_KEY_D, {8'h00, exp}, cycle + 1);
    step();
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    step();
    step();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hold);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (hold) step();
    ioctl_wr = 1'b0;
    step();
  endtask

  // Ends a key download and checks the CHECK cycle and the status edge after
  // it. If last_wr is set, the final byte's strobe rises together with downl
  // falling.
  task automatic end_load(input logic last_wr, input logic [24:0] a, input logic [7:0] d,
                          input logic exp_valid, input int exp_cnt);
    int c;
    c = cycle;
    ioctl_downl = 1'b0;
    if (last_wr) begin
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
    end
    expect_at(K_STATE, 16'(CHECK), c + 2);
    expect_at(K_VALID, 16'h0,      c + 2);
    expect_at(K_ERR,   16'h0,      c + 2);
    expect_at(K_COUNT, 16'(exp_cnt), c + 2);
    expect_at(K_STATE, 16'(IDLE),  c + 3);
    expect_at(K_VALID, {15'h0, exp_valid},  c + 3);
    expect_at(K_ERR,   {15'h0, ~exp_valid}, c + 3);
    repeat (3) step();
    ioctl_wr = 1'b0;
    repeat (2) step();
  endtask

  function automatic logic [24:0] kaddr(input int off);
    return KEY_BASE + 25'(off);
  endfunction

  function automatic logic [7:0] pat(input int off, input logic [7:0] m);
    logic [24:0] a;
    a = KEY_BASE + 25'(off);
    return a[7:0] ^ m;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_index = 8'h00;
    ioctl_addr  = 25'h0;
    ioctl_dout  = 8'h00;
    ioctl_wr    = 1'b0;
    key_a       = 13'h0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Reset state.
    expect_status(1'b0, 1'b0, 0, IDLE);
    check_key(13'h1234, 8'hFF);

    // Full load, 3-clk strobes; last byte coincides with downl falling.
    start_load(KEY_INDEX);
    for (int i = 0; i < 8191; i++) send_byte(kaddr(i), pat(i, 8'h5A), 3);
    end_load(1'b1, kaddr(8191), pat(8191, 8'h5A), 1'b1, 8192);
    expect_status(1'b1, 1'b0, 8192, IDLE);
    check_key(13'h1234, 8'h6E);
    check_key(13'h0000, 8'h5A);
    check_key(13'h1FFF, 8'hA5);

    // Foreign stream: never leaves IDLE, key untouched.
    start_load(KEY_INDEX + 8'd1);
    send_byte(kaddr(13'h1234), 8'h00, 1);
    expect_status(1'b1, 1'b0, 8192, IDLE);
    ioctl_downl = 1'b0;
    repeat (3) step();
    expect_status(1'b1, 1'b0, 8192, IDLE);
    check_key(13'h1234, 8'h6E);

    // Short load: 8191 bytes.
    start_load(KEY_INDEX);
    expect_status(1'b0, 1'b0, 0, LOAD);
    check_key(13'h1234, 8'hFF);
    for (int i = 0; i < 8191; i++) send_byte(kaddr(i), pat(i, 8'hC3), 1);
    end_load(1'b0, 25'h0, 8'h00, 1'b0, 8191);
    expect_status(1'b0, 1'b1, 8191, IDLE);
    check_key(13'h1234, 8'hFF);
    check_key(13'h0000, 8'hFF);

    // Reset mid-load after 4000 bytes: reset values appear before the next edge.
    start_load(KEY_INDEX);
    for (int i = 0; i < 4000; i++) send_byte(kaddr(i), pat(i, 8'h3C), 1);
    expect_status(1'b0, 1'b0, 4000, LOAD);
    step();
    reset_n = 1'b0;
    expect_status(1'b0, 1'b0, 0, IDLE);
    expect_at(K_KEY_D, 16'h00FF, cycle);
    ioctl_downl = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Full load with out-of-range bytes mixed in.
    start_load(KEY_INDEX);
    for (int i = 0; i < 100; i++) send_byte(kaddr(i), pat(i, 8'hA5), 1);
    send_byte(KEY_BASE - 25'd1,     8'h00, 1);
    send_byte(KEY_BASE + 25'd8192,  8'h00, 1);
    expect_status(1'b0, 1'b0, 100, LOAD);
    for (int i = 100; i < 8192; i++) send_byte(kaddr(i), pat(i, 8'hA5), 1);
    send_byte(KEY_BASE - 25'd1,     8'h00, 1);
    send_byte(KEY_BASE + 25'd8192,  8'h00, 1);
    end_load(1'b0, 25'h0, 8'h00, 1'b1, 8192);
    expect_status(1'b1, 1'b0, 8192, IDLE);
    check_key(13'h1234, 8'h91);
    check_key(13'h0000, 8'hA5);
    check_key(13'h1FFF, 8'h5A);

    // Long strobes: 10 clocks per byte, one count per byte.
    start_load(KEY_INDEX);
    expect_status(1'b0, 1'b0, 0, LOAD);
    check_key(13'h1234, 8'hFF);
    for (int i = 0; i < 16; i++) send_byte(kaddr(i), pat(i, 8'hA5), 10);
    expect_status(1'b0, 1'b0, 16, LOAD);
    end_load(1'b0, 25'h0, 8'h00, 1'b0, 16);
    expect_status(1'b0, 1'b1, 16, IDLE);

    repeat (3) step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    finished = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got cycle %0d expected completion", cycle);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

endmodule
